// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end types and constants
// Purpose: types shared by the fetch buffer and its storage array.
//   INSTR_NOP     : instruction word presented to decode when no entry is valid
//   fetch_entry_t : one queued fetch {pc, instr, misalign}
package cpu_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

endpackage : cpu_pkg

// File: rtl/fetch_fifo_mem.sv
// rtl/fetch_fifo_mem.sv - register array backing the fetch queue
// Purpose: DEPTH-entry storage with one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by
// the pointer/count logic in fetch_buffer.
// Ports:
//   clk   : clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : entry written at waddr on the rising edge when we is high
//   raddr : read address
//   rdata : entry at raddr (combinational)
module fetch_fifo_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  fetch_entry_t       wdata,
  input  logic [PTR_W-1:0]   raddr,
  output fetch_entry_t       rdata
);

  fetch_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fetch_fifo_mem

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - instruction fetch queue between PC unit and decode
// Purpose: queues {pc, instr, misalign} fetches, presents the oldest to
// decode with a valid/ready handshake, pauses the PC unit when full and
// discards everything on a taken branch/jump (flush).
// Optional feature: define FETCH_BUF_BYPASS_EN to forward a fetch straight
// to decode in the same cycle when the queue is empty.
// Ports:
//   clk, PcReSet          : clock (rising edge), async active-high reset
//   pc_in, instr_in       : fetch PC and instruction memory data for it
//   fetch_valid           : pc_in/instr_in are a valid fetch this cycle
//   flush                 : taken branch or jump, discards the queue
//   id_ready              : decode accepts the head entry this cycle
//   id_valid              : head entry present
//   id_pc, id_pc_plus4    : head PC and head PC + 4
//   id_instr, id_misalign : head instruction and misaligned-fetch flag
//   pause                 : queue full, PC unit must hold
//   count                 : occupancy 0..DEPTH
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             PcReSet,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             fetch_valid,
  input  logic             flush,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc_plus4,
  output logic [31:0]      id_instr,
  output logic             id_misalign,
  output logic             pause,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   count_q, count_d;

  logic         empty;
  logic         full;
  logic         push;
  logic         pop;
  logic         bypass;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;
  fetch_entry_t head;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  assign wr_entry.pc       = pc_in;
  assign wr_entry.instr    = instr_in;
  assign wr_entry.misalign = |pc_in[1:0];

`ifdef FETCH_BUF_BYPASS_EN
  // An empty queue forwards the fetch directly; if decode takes it in the
  // same cycle it never occupies a slot.
  assign bypass = empty & fetch_valid & ~flush;
  assign push   = fetch_valid & ~full & ~flush & ~(bypass & id_ready);
`else
  assign bypass = 1'b0;
  assign push   = fetch_valid & ~full & ~flush;
`endif

  // Pop only ever drains a real queued entry, never a bypassed one.
  assign pop = ~empty & id_ready & ~flush;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wp_d = wp_q + 1'b1;
      end
      if (pop) begin
        rp_d = rp_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  fetch_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wp_q),
    .wdata (wr_entry),
    .raddr (rp_q),
    .rdata (rd_entry)
  );

  // Empty queue shows a zeroed NOP entry so stale storage never leaks out.
  always_comb begin
    head       = '0;
    head.instr = INSTR_NOP;
    id_valid   = 1'b0;
    if (!empty) begin
      head     = rd_entry;
      id_valid = 1'b1;
    end else if (bypass) begin
      head     = wr_entry;
      id_valid = 1'b1;
    end
  end

  assign id_pc       = head.pc;
  assign id_pc_plus4 = head.pc + 32'd4;
  assign id_instr    = head.instr;
  assign id_misalign = head.misalign;
  assign pause       = full;
  assign count       = count_q;

endmodule : fetch_buffer
